// File: rtl/bias_seq_pkg.sv
// Shared types and constants for the bias sequencer.
// Included by bias_seq_buf and bias_seq_ctrl.
package bias_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int BUF_DEPTH = 2;
    localparam int STALL_W   = 32;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/bias_seq_if.sv
// ROM read port and ap_fifo output stream of the bias sequencer.
// master = sequencer side, slave = ROM/stream side.
interface bias_seq_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);

    logic [ADDR_W-1:0] bias_V_address0;
    logic              bias_V_ce0;
    logic [DATA_W-1:0] bias_V_q0;
    logic [DATA_W-1:0] output_V_din;
    logic              output_V_full_n;
    logic              output_V_write;

    modport master (
        output bias_V_address0,
        output bias_V_ce0,
        input  bias_V_q0,
        output output_V_din,
        input  output_V_full_n,
        output output_V_write
    );

    modport slave (
        input  bias_V_address0,
        input  bias_V_ce0,
        output bias_V_q0,
        input  output_V_din,
        output output_V_full_n,
        input  output_V_write
    );

endinterface

// File: rtl/bias_seq_buf.sv
// Two-entry synchronous FIFO holding ROM words on their way to the stream.
// Head is combinational from storage so it stays stable while stalled.
module bias_seq_buf
    import bias_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/bias_seq_ctrl.sv
// Streams NUM_BIAS bias words REPEAT times from a 1-cycle ROM into an ap_fifo.
// Optional stall counter port under `BIAS_SEQ_STALL_CNT_EN.
module bias_seq_ctrl
    import bias_seq_pkg::*;
#(
    parameter int NUM_BIAS = 16,
    parameter int DATA_W   = 16,
    parameter int REPEAT   = 1,
    parameter int ADDR_W   = $clog2(NUM_BIAS)
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
`ifdef BIAS_SEQ_STALL_CNT_EN
    output logic [STALL_W-1:0] stall_count,
`endif
    bias_seq_if.master         bus
);

    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BIAS - 1);
    localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(REPEAT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [REP_W-1:0]  rep_q;
    logic              inflight_q;
    logic              inflight_d;
    logic              done_q;
    logic              idle_q;

    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  used_d;
    logic [DATA_W-1:0] head;
    logic              wr;
    logic              accept;
    logic              last_issue;
    logic              drained;

    // Slots committed after this cycle: buffered + in flight - leaving now.
    assign wr         = (occ != '0) && bus.output_V_full_n;
    assign used_d     = occ + CNT_W'(inflight_q) - CNT_W'(wr);
    assign inflight_d = (state_q == RUN) && (used_d < CNT_W'(BUF_DEPTH));
    assign last_issue = inflight_d && (addr_q == LAST_ADDR) && (rep_q == LAST_REP);
    assign accept     = (state_q == IDLE) && idle_q && ap_start;
    // Buffer will be empty with nothing in flight after this edge.
    assign drained    = (state_q == DRAIN) && !inflight_q && (occ == CNT_W'(wr));

    bias_seq_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk_i   (ap_clk),
        .rst_i   (ap_rst),
        .push_i  (inflight_q),
        .pop_i   (wr),
        .data_i  (bus.bias_V_q0),
        .head_o  (head),
        .count_o (occ)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rep_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            inflight_q <= inflight_d;
            done_q     <= 1'b0;
            if (inflight_d) begin
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    rep_q  <= rep_q + REP_W'(1);
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= '0;
                        rep_q   <= '0;
                        idle_q  <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BIAS_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst || accept) begin
            stall_q <= '0;
        end else if ((occ != '0) && !bus.output_V_full_n && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_count = stall_q;
`endif

    assign ap_done             = done_q;
    assign ap_idle             = idle_q;
    assign bus.bias_V_address0 = addr_q;
    assign bus.bias_V_ce0      = inflight_d;
    assign bus.output_V_din    = head;
    assign bus.output_V_write  = wr;

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Directed bench for bias_seq_ctrl: NUM_BIAS=4, ROM={10,20,30,40},
// REPEAT=3 main instance plus a REPEAT=1 instance.
module tb_bias_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start0, full_n0, done0, idle0;
    logic start1, full_n1, done1, idle1;
`ifdef BIAS_SEQ_STALL_CNT_EN
    logic [31:0] sc0, sc1;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bias_seq_if #(.ADDR_W(2), .DATA_W(16)) if0 ();
    bias_seq_if #(.ADDR_W(2), .DATA_W(16)) if1 ();

    bias_seq_ctrl #(
        .NUM_BIAS (4), .DATA_W (16), .REPEAT (3), .ADDR_W (2)
    ) u0 (
        .ap_clk      (clk),
        .ap_rst      (rst),
        .ap_start    (start0),
        .ap_done     (done0),
        .ap_idle     (idle0),
`ifdef BIAS_SEQ_STALL_CNT_EN
        .stall_count (sc0),
`endif
        .bus         (if0)
    );

    bias_seq_ctrl #(
        .NUM_BIAS (4), .DATA_W (16), .REPEAT (1), .ADDR_W (2)
    ) u1 (
        .ap_clk      (clk),
        .ap_rst      (rst),
        .ap_start    (start1),
        .ap_done     (done1),
        .ap_idle     (idle1),
`ifdef BIAS_SEQ_STALL_CNT_EN
        .stall_count (sc1),
`endif
        .bus         (if1)
    );

    function automatic logic [15:0] rom_val(input logic [1:0] a);
        return 16'(10 * (int'(a) + 1));
    endfunction

    function automatic logic [15:0] exp_word(input int n);
        return 16'(10 * ((n % 4) + 1));
    endfunction

    always_ff @(posedge clk) begin
        if (if0.bias_V_ce0) if0.bias_V_q0 <= rom_val(if0.bias_V_address0);
        if (if1.bias_V_ce0) if1.bias_V_q0 <= rom_val(if1.bias_V_address0);
    end

    assign if0.output_V_full_n = full_n0;
    assign if1.output_V_full_n = full_n1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // mode 0: full_n=1; 1: full_n 1,0,0,1 repeating; 2: 50-cycle stall after first write
    task automatic run_seq(input int mode, input bit hold, input string nm);
        int nw, nd, bad, occ, stall_c, stall_left, ce_stall, cyc, extra;
        int last_wr, done_cyc;
        bit ce_prev;
        logic [15:0] res_din;
        nw = 0; nd = 0; bad = 0; occ = 0; stall_c = 0; stall_left = 0;
        ce_stall = 0; cyc = 0; extra = 0; last_wr = -10; done_cyc = 0;
        ce_prev = 1'b0; res_din = '0;
        while (nd == 0 && cyc < 400) begin
            @(posedge clk); #1;
            start0 = (cyc == 0) || hold;
            if (mode == 1) full_n0 = (cyc % 4 == 0) || (cyc % 4 == 3);
            else if (mode == 2 && stall_left > 0) begin
                full_n0 = 1'b0;
                stall_left--;
            end else full_n0 = 1'b1;
            @(negedge clk);
            if (if0.output_V_write !== ((occ > 0) && full_n0)) bad++;
            if (occ > 0 && if0.output_V_din !== exp_word(nw)) bad++;
            if (occ > 2) bad++;
            if (done0 && idle0) bad++;
            if (occ > 0 && !full_n0) stall_c++;
            if (mode == 2 && !full_n0 && if0.bias_V_ce0) ce_stall++;
            if (done0) begin
                nd++;
                done_cyc = cyc;
            end
            if (if0.output_V_write) begin
                if (mode == 2 && nw == 0) stall_left = 50;
                if (mode == 2 && nw == 1) res_din = if0.output_V_din;
                nw++;
                last_wr = cyc;
            end
            occ = occ + int'(ce_prev) - int'(if0.output_V_write);
            ce_prev = if0.bias_V_ce0;
            cyc++;
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            full_n0 = 1'b1;
            @(negedge clk);
            if (if0.output_V_write || done0) extra++;
        end
        chk({nm, "_done_seen"}, 32'(nd > 0), 1);
        chk({nm, "_writes"}, nw, 12);
        chk({nm, "_protocol"}, bad, 0);
        chk({nm, "_after_done"}, extra, 0);
        chk({nm, "_done_lat"}, done_cyc - last_wr, 1);
        if (mode == 2) begin
            chk({nm, "_ce_in_stall"}, ce_stall, 0);
            chk({nm, "_resume_din"}, res_din, 20);
        end
`ifdef BIAS_SEQ_STALL_CNT_EN
        chk({nm, "_stall_count"}, sc0, stall_c);
`endif
    endtask

    typedef struct {
        logic        start;
        logic        full_n;
        logic        ce;
        logic        wr;
        logic [15:0] din;
        logic        done;
        logic        idle;
    } vec_t;

    vec_t vt [17];
    int   nw, bad, n1, bad1, nd1, lw1, dc1;

    initial begin
        for (int i = 0; i < 17; i++) begin
            vt[i].start  = (i == 0);
            vt[i].full_n = 1'b1;
            vt[i].ce     = (i >= 1 && i <= 12);
            vt[i].wr     = (i >= 3 && i <= 14);
            vt[i].din    = vt[i].wr ? exp_word(i - 3) : 16'd0;
            vt[i].done   = (i == 15);
            vt[i].idle   = (i == 0 || i == 16);
        end

        rst = 1'b1;
        start0 = 1'b0; full_n0 = 1'b1;
        start1 = 1'b0; full_n1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_idle", idle0, 1);
        chk("rst_done", done0, 0);
        chk("rst_ce", if0.bias_V_ce0, 0);
        chk("rst_write", if0.output_V_write, 0);
        chk("rst_addr", if0.bias_V_address0, 0);
        chk("rst_din", if0.output_V_din, 0);

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            start0  = vt[i].start;
            full_n0 = vt[i].full_n;
            @(negedge clk);
            chk($sformatf("smoke%0d_ce", i), if0.bias_V_ce0, vt[i].ce);
            chk($sformatf("smoke%0d_wr", i), if0.output_V_write, vt[i].wr);
            chk($sformatf("smoke%0d_done", i), done0, vt[i].done);
            chk($sformatf("smoke%0d_idle", i), idle0, vt[i].idle);
            if (vt[i].wr) chk($sformatf("smoke%0d_din", i), if0.output_V_din, vt[i].din);
        end

        run_seq(1, 1'b0, "bp");
        run_seq(2, 1'b0, "long");

        nw = 0;
        @(posedge clk); #1;
        start0 = 1'b1; full_n0 = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 30 && nw < 5; c++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            @(negedge clk);
            if (if0.output_V_write) nw++;
        end
        chk("mid_pre_writes", nw, 5);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_idle", idle0, 1);
        chk("mid_write", if0.output_V_write, 0);
        chk("mid_ce", if0.bias_V_ce0, 0);
        chk("mid_done", done0, 0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (if0.output_V_write || done0 || if0.bias_V_ce0) bad++;
        end
        chk("mid_quiet", bad, 0);
        run_seq(0, 1'b0, "rerun");

        run_seq(0, 1'b1, "hold");

        n1 = 0; bad1 = 0; nd1 = 0; lw1 = -10; dc1 = 0;
        @(posedge clk); #1 start1 = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 40 && nd1 == 0; c++) begin
            @(posedge clk); #1 start1 = 1'b0;
            @(negedge clk);
            if (if1.output_V_write) begin
                if (if1.output_V_din !== exp_word(n1)) bad1++;
                n1++;
                lw1 = c;
            end
            if (done1) begin
                nd1++;
                dc1 = c;
            end
        end
        chk("rep1_writes", n1, 4);
        chk("rep1_order", bad1, 0);
        chk("rep1_done", nd1, 1);
        chk("rep1_done_lat", dc1 - lw1, 1);
`ifdef BIAS_SEQ_STALL_CNT_EN
        chk("rep1_stall_count", sc1, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
